// File: rtl/go_pkg.sv
`default_nettype none
// ============================================================================
// Module   : go_pkg
// Purpose  : Shared types and constants for the move arbiter and its timer.
// Revision : 1.0  initial release
// ============================================================================
package go_pkg;

    typedef logic [7:0] move_t;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ISSUE    = 3'd1,
        WAIT_RES = 3'd2,
        TX_SEND  = 3'd3,
        TX_WAIT  = 3'd4,
        OVER     = 3'd5
    } arb_state_e;

    typedef enum logic {
        LOCAL  = 1'b0,
        REMOTE = 1'b1
    } src_e;

    localparam move_t PASS_MOVE = 8'hFF;
    localparam logic  BLACK     = 1'b0;
    localparam logic  WHITE     = 1'b1;

    function automatic logic is_owner(input logic turn, input logic color);
        return (turn == BLACK) ? (color == BLACK) : (color == WHITE);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cycle_timer.sv
`default_nettype none
// ============================================================================
// Module   : cycle_timer
// Purpose  : Clearable up-counter that holds at CYCLES-1 and flags it.
// Revision : 1.0  initial release
// ============================================================================
module cycle_timer #(
    parameter int CYCLES = 1024
) (
    input  logic clk_in,
    input  logic rst_in_n,
    input  logic clear,
    input  logic enable,
    output logic done
);

    localparam int c_cw = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [c_cw-1:0] r_count;

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !done) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign done = (r_count == c_cw'(CYCLES - 1));

endmodule
`default_nettype wire

// File: rtl/move_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : move_arbiter
// Purpose  : Shares game_fsm's move port between local player and remote
//            opponent; forwards accepted local moves to the UART transmitter.
// Revision : 1.0  initial release
// ============================================================================
module move_arbiter
    import go_pkg::*;
#(
    parameter int    TIMEOUT_CYCLES = 1024,
    parameter move_t PASS_CODE      = PASS_MOVE,
    parameter int    REJ_W          = 8
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic             my_color,
    input  logic             turn,
    input  logic             tx_ready,
    input  logic             invalid_move,
    input  logic             game_over,
    input  logic             local_valid,
    input  logic [7:0]       local_move,
    output logic             local_ready,
    input  logic             remote_valid,
    input  logic [7:0]       remote_move,
    output logic [7:0]       move,
    output logic             move_avail,
    input  logic             uart_tx_busy,
    output logic             uart_tx_start,
    output logic [7:0]       uart_tx_data,
    output logic             reject_pulse,
    output logic             remote_err,
    output logic [REJ_W-1:0] reject_cnt
);

    // Passes travel through the same path as board moves; the encoding only
    // has to agree with game_fsm.
    if (PASS_CODE != PASS_MOVE) begin : g_custom_pass_code
    end

    arb_state_e r_state;
    move_t      r_move_q;
    src_e       r_src;
    logic       r_turn_q;
    logic       r_grace;
    logic       r_over_pend;
    logic       r_busy_seen;
    logic       r_rise_cnt;

    logic w_owner_local;
    logic w_timer_clear;
    logic w_timer_en;
    logic w_timer_done;
    logic w_wait_live;
    logic w_accept;
    logic w_reject;
    logic w_remote_drop;
    logic w_tx_done;
    logic w_end_game;

    assign w_owner_local = is_owner(turn, my_color);
    assign local_ready   = rst_in_n && (r_state == IDLE) && !game_over
                           && w_owner_local && local_valid;

    assign w_wait_live   = (r_state == WAIT_RES) && !r_grace;
    assign w_accept      = w_wait_live && !invalid_move
                           && ((turn != r_turn_q) || game_over);
    assign w_reject      = w_wait_live && (invalid_move || (!w_accept && w_timer_done));

    // Bytes are only consumed in IDLE while the opponent owns the turn.
    assign w_remote_drop = remote_valid
                           && !((r_state == IDLE) && !game_over && !w_owner_local);

    assign w_tx_done     = !uart_tx_busy && (r_busy_seen || r_rise_cnt);
    assign w_end_game    = game_over || r_over_pend;

    assign w_timer_clear = (r_state == ISSUE);
    assign w_timer_en    = w_wait_live;

    cycle_timer #(
        .CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk_in   (clk_in),
        .rst_in_n (rst_in_n),
        .clear    (w_timer_clear),
        .enable   (w_timer_en),
        .done     (w_timer_done)
    );

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            r_state       <= IDLE;
            r_move_q      <= '0;
            r_src         <= LOCAL;
            r_turn_q      <= 1'b0;
            r_grace       <= 1'b0;
            r_over_pend   <= 1'b0;
            r_busy_seen   <= 1'b0;
            r_rise_cnt    <= 1'b0;
            move          <= '0;
            move_avail    <= 1'b0;
            uart_tx_start <= 1'b0;
            uart_tx_data  <= '0;
            reject_pulse  <= 1'b0;
            remote_err    <= 1'b0;
            reject_cnt    <= '0;
        end else begin
            move_avail    <= 1'b0;
            uart_tx_start <= 1'b0;
            reject_pulse  <= 1'b0;
            remote_err    <= w_remote_drop;

            if (w_reject) begin
                reject_pulse <= 1'b1;
                if (reject_cnt != '1) begin
                    reject_cnt <= reject_cnt + 1'b1;
                end
            end

            case (r_state)
                IDLE: begin
                    r_over_pend <= 1'b0;
                    if (game_over) begin
                        r_state <= OVER;
                    end else if (w_owner_local) begin
                        if (local_valid) begin
                            r_move_q   <= local_move;
                            move       <= local_move;
                            move_avail <= 1'b1;
                            r_src      <= LOCAL;
                            r_state    <= ISSUE;
                        end
                    end else if (remote_valid) begin
                        r_move_q   <= remote_move;
                        move       <= remote_move;
                        move_avail <= 1'b1;
                        r_src      <= REMOTE;
                        r_state    <= ISSUE;
                    end
                end

                ISSUE: begin
                    r_turn_q <= turn;
                    r_grace  <= 1'b0;
                    r_state  <= WAIT_RES;
                end

                WAIT_RES: begin
                    if (r_grace) begin
                        // One extra cycle for tx_ready lagging the turn change.
                        r_grace <= 1'b0;
                        if (tx_ready && (r_src == LOCAL)) begin
                            r_state <= TX_SEND;
                        end else begin
                            r_state <= w_end_game ? OVER : IDLE;
                        end
                    end else if (w_reject) begin
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        r_over_pend <= game_over;
                        if (r_src == LOCAL) begin
                            if (tx_ready) begin
                                r_state <= TX_SEND;
                            end else begin
                                r_grace <= 1'b1;
                            end
                        end else begin
                            r_state <= game_over ? OVER : IDLE;
                        end
                    end
                end

                TX_SEND: begin
                    if (!uart_tx_busy) begin
                        uart_tx_start <= 1'b1;
                        uart_tx_data  <= r_move_q;
                        r_busy_seen   <= 1'b0;
                        r_rise_cnt    <= 1'b0;
                        r_state       <= TX_WAIT;
                    end
                end

                TX_WAIT: begin
                    if (uart_tx_busy) begin
                        r_busy_seen <= 1'b1;
                    end else if (!r_busy_seen) begin
                        r_rise_cnt <= 1'b1;
                    end
                    if (w_tx_done) begin
                        r_state <= w_end_game ? OVER : IDLE;
                    end
                end

                OVER: begin
                    r_state <= OVER;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_move_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_move_arbiter
// Purpose  : Scoreboard bench for move_arbiter with a game_fsm/UART model.
// Revision : 1.0  initial release
// ============================================================================
module tb_move_arbiter;
    import go_pkg::*;

    localparam int c_timeout = 16;
    localparam int c_rej_w   = 2;
    localparam int c_rej_max = (1 << c_rej_w) - 1;

    logic               clk_in;
    logic               rst_in_n;
    logic               my_color;
    logic               turn;
    logic               tx_ready;
    logic               invalid_move;
    logic               game_over;
    logic               local_valid;
    logic [7:0]         local_move;
    logic               local_ready;
    logic               remote_valid;
    logic [7:0]         remote_move;
    logic [7:0]         move;
    logic               move_avail;
    logic               uart_tx_busy;
    logic               uart_tx_start;
    logic [7:0]         uart_tx_data;
    logic               reject_pulse;
    logic               remote_err;
    logic [c_rej_w-1:0] reject_cnt;

    int total = 0;
    int bad   = 0;
    int avail_cnt = 0;
    int tx_cnt    = 0;
    int rej_seen  = 0;
    int err_seen  = 0;
    int busy_left = 0;
    logic hold_busy = 1'b0;

    logic [7:0] exp_move[$];
    logic [7:0] exp_tx[$];

    move_arbiter #(
        .TIMEOUT_CYCLES (c_timeout),
        .PASS_CODE      (PASS_MOVE),
        .REJ_W          (c_rej_w)
    ) dut (
        .clk_in        (clk_in),
        .rst_in_n      (rst_in_n),
        .my_color      (my_color),
        .turn          (turn),
        .tx_ready      (tx_ready),
        .invalid_move  (invalid_move),
        .game_over     (game_over),
        .local_valid   (local_valid),
        .local_move    (local_move),
        .local_ready   (local_ready),
        .remote_valid  (remote_valid),
        .remote_move   (remote_move),
        .move          (move),
        .move_avail    (move_avail),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_start (uart_tx_start),
        .uart_tx_data  (uart_tx_data),
        .reject_pulse  (reject_pulse),
        .remote_err    (remote_err),
        .reject_cnt    (reject_cnt)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    // Scoreboard pops and event counters
    initial begin
        forever begin
            @(negedge clk_in);
            if (move_avail) begin
                avail_cnt++;
                check("avail_expected", exp_move.size() != 0, 1);
                if (exp_move.size() != 0) check("move", move, exp_move.pop_front());
            end
            if (uart_tx_start) begin
                tx_cnt++;
                check("tx_expected", exp_tx.size() != 0, 1);
                if (exp_tx.size() != 0) check("tx_data", uart_tx_data, exp_tx.pop_front());
            end
            if (reject_pulse) rej_seen++;
            if (remote_err)   err_seen++;
        end
    end

    // UART transmitter model: busy for three cycles after each start
    initial begin
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk_in);
            if (uart_tx_start) busy_left = 3;
            if (busy_left > 0) begin
                uart_tx_busy = 1'b1;
                busy_left--;
            end else begin
                uart_tx_busy = hold_busy;
            end
        end
    end

    task automatic send_local(input logic [7:0] m);
        local_valid = 1'b1;
        local_move  = m;
        exp_move.push_back(m);
        #1 check("local_ready", local_ready, 1);
        tick();
        local_valid = 1'b0;
    endtask

    task automatic send_remote(input logic [7:0] m);
        remote_valid = 1'b1;
        remote_move  = m;
        exp_move.push_back(m);
        tick();
        remote_valid = 1'b0;
    endtask

    task automatic wait_state(input arb_state_e s, input string tag);
        int n = 0;
        while (dut.r_state != s && n < 60) begin
            tick();
            n++;
        end
        check(tag, dut.r_state, s);
    endtask

    initial begin
        int a0, t0, r0, e0, n, rej_model;
        rst_in_n = 1'b1;
        my_color = BLACK;
        turn = BLACK;
        tx_ready = 0; invalid_move = 0; game_over = 0;
        local_valid = 0; local_move = 0; remote_valid = 0; remote_move = 0;
        rej_model = 0;
        #2 rst_in_n = 1'b0;
        tick(); tick();
        check("rst_move", move, 0);
        check("rst_avail", move_avail, 0);
        check("rst_txstart", uart_tx_start, 0);
        check("rst_rejcnt", reject_cnt, 0);
        check("rst_state", dut.r_state, IDLE);
        rst_in_n = 1'b1;
        tick();

        // 1: local move forwarded to UART
        a0 = avail_cnt; t0 = tx_cnt;
        send_local(8'h34);
        check("issue_latency", avail_cnt - a0, 1);
        tick();
        turn = WHITE; tx_ready = 1'b1; exp_tx.push_back(8'h34);
        tick();
        tx_ready = 1'b0;
        wait_state(IDLE, "t1_idle");
        check("t1_tx_count", tx_cnt - t0, 1);

        // 2: remote move, no transmission
        t0 = tx_cnt; a0 = avail_cnt;
        send_remote(8'h22);
        check("t2_avail", avail_cnt - a0, 1);
        tick();
        turn = BLACK;
        tick();
        wait_state(IDLE, "t2_idle");
        repeat (4) tick();
        check("t2_no_tx", tx_cnt - t0, 0);

        // 3: rejected local move
        r0 = rej_seen;
        send_local(8'h00);
        tick();
        invalid_move = 1'b1;
        tick();
        invalid_move = 1'b0;
        rej_model++;
        check("t3_reject", rej_seen - r0, 1);
        check("t3_rejcnt", reject_cnt, rej_model);
        check("t3_no_tx", tx_cnt - t0, 0);
        local_valid = 1'b1;
        #1 check("t3_ready_again", local_ready, 1);
        local_valid = 1'b0;

        // 4: remote byte out of turn
        e0 = err_seen; a0 = avail_cnt;
        remote_valid = 1'b1; remote_move = 8'h99;
        tick();
        remote_valid = 1'b0;
        check("t4_remote_err", err_seen - e0, 1);
        repeat (5) tick();
        check("t4_no_avail", avail_cnt - a0, 0);

        // 5: timeout; move_avail marks ISSUE, 16 WAIT_RES cycles follow
        r0 = rej_seen;
        send_local(8'h77);
        n = 0;
        while (rej_seen == r0 && n < 40) begin
            tick();
            n++;
        end
        rej_model++;
        check("t5_timeout_cycles", n, 17);
        check("t5_rejcnt", reject_cnt, rej_model);
        for (int i = 0; i < 2; i++) begin
            send_local(8'h10 + 8'(i));
            tick();
            invalid_move = 1'b1;
            tick();
            invalid_move = 1'b0;
            rej_model++;
            check("sat_rejcnt", reject_cnt, (rej_model > c_rej_max) ? c_rej_max : rej_model);
        end

        // 6: passes, game over, then reset mid TX_SEND
        t0 = tx_cnt;
        send_local(PASS_MOVE);
        tick();
        turn = WHITE; tx_ready = 1'b1; exp_tx.push_back(PASS_MOVE);
        tick();
        tx_ready = 1'b0;
        wait_state(IDLE, "t6_idle");
        check("t6_pass_tx", tx_cnt - t0, 1);
        send_remote(PASS_MOVE);
        tick();
        game_over = 1'b1;
        tick();
        wait_state(OVER, "t6_over");
        a0 = avail_cnt; e0 = err_seen;
        local_valid = 1'b1; local_move = 8'h12; remote_valid = 1'b1;
        #1 check("t6_over_noready", local_ready, 0);
        tick();
        local_valid = 1'b0; remote_valid = 1'b0;
        check("t6_over_err", err_seen - e0, 1);
        repeat (4) tick();
        check("t6_over_noavail", avail_cnt - a0, 0);
        check("t6_still_over", dut.r_state, OVER);

        rst_in_n = 1'b0;
        tick();
        check("rst2_state", dut.r_state, IDLE);
        check("rst2_rejcnt", reject_cnt, 0);
        rst_in_n = 1'b1; game_over = 1'b0; turn = BLACK; hold_busy = 1'b1;
        tick();
        send_local(8'h45);
        tick();
        turn = WHITE; tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        tick();
        check("t6_in_txsend", dut.r_state, TX_SEND);
        check("t6_move_held", move, 8'h45);
        local_valid = 1'b1;
        rst_in_n = 1'b0;
        #1;
        check("arst_move", move, 0);
        check("arst_avail", move_avail, 0);
        check("arst_ready", local_ready, 0);
        check("arst_txstart", uart_tx_start, 0);
        check("arst_txdata", uart_tx_data, 0);
        check("arst_reject", reject_pulse, 0);
        check("arst_err", remote_err, 0);
        check("arst_state", dut.r_state, IDLE);
        local_valid = 1'b0; hold_busy = 1'b0;
        tick();
        rst_in_n = 1'b1;
        tick();
        check("final_tx_queue", exp_tx.size(), 0);
        check("final_move_queue", exp_move.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
